// File: rtl/julia_pixel_scanner.sv
// Raster-order frame scanner: feeds one Q16.16 coordinate at a time to the Julia
// engine over enable/calc_end and forwards each colour to the frame buffer.
module julia_pixel_scanner #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [31:0]  x_start,
  input  logic signed [31:0]  y_start,
  input  logic signed [31:0]  step_x,
  input  logic signed [31:0]  step_y,
  input  logic signed [31:0]  cr_in,
  input  logic signed [31:0]  ci_in,
  output logic                busy,
  output logic                done,
  output logic [15:0]         frame_count,
  output logic                calc_enable,
  output logic signed [31:0]  calc_x,
  output logic signed [31:0]  calc_y,
  output logic signed [31:0]  calc_cr,
  output logic signed [31:0]  calc_ci,
  input  logic                calc_end,
  input  logic [15:0]         calc_color,
  output logic                fb_we,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [15:0]         fb_data,
  input  logic                fb_ready
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic signed [31:0] x_base;
  logic signed [31:0] step_x_q;
  logic signed [31:0] step_y_q;

  logic last_col;
  logic last_row;

  always_comb begin
    last_col = (col == LAST_COL);
    last_row = (row == LAST_ROW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      col         <= '0;
      row         <= '0;
      x_base      <= '0;
      step_x_q    <= '0;
      step_y_q    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
      calc_enable <= 1'b0;
      calc_x      <= '0;
      calc_y      <= '0;
      calc_cr     <= '0;
      calc_ci     <= '0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_base   <= x_start;
            step_x_q <= step_x;
            step_y_q <= step_y;
            calc_x   <= x_start;
            calc_y   <= y_start;
            calc_cr  <= cr_in;
            calc_ci  <= ci_in;
            col      <= '0;
            row      <= '0;
            fb_addr  <= '0;
            busy     <= 1'b1;
            state    <= S_SETUP;
          end
        end

        // Engine is held in reset for this one cycle so it reloads the operands.
        S_SETUP: begin
          calc_enable <= 1'b1;
          state       <= S_RUN;
        end

        S_RUN: begin
          if (calc_end) begin
            fb_data     <= calc_color;
            calc_enable <= 1'b0;
            fb_we       <= 1'b1;
            state       <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (fb_ready) begin
            fb_we <= 1'b0;
            if (last_col && last_row) begin
              // Leave the write port at its idle values before returning to IDLE.
              busy        <= 1'b0;
              done        <= 1'b1;
              frame_count <= frame_count + 16'd1;
              fb_addr     <= '0;
              fb_data     <= '0;
              state       <= S_DONE;
            end else if (last_col) begin
              col     <= '0;
              row     <= row + ROW_W'(1);
              calc_x  <= x_base;
              calc_y  <= calc_y - step_y_q;
              fb_addr <= fb_addr + ADDR_W'(1);
              state   <= S_SETUP;
            end else begin
              col     <= col + COL_W'(1);
              calc_x  <= calc_x + step_x_q;
              fb_addr <= fb_addr + ADDR_W'(1);
              state   <= S_SETUP;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
